uart_wb_bridge: RTL and testbench

UART-to-Wishbone debug bridge for the management SoC. It receives 8N1 command frames on `rx`, runs the corresponding single-word or incrementing Wishbone master cycles, and returns read data on `tx`. It is the device-side responder to the host debug protocol. The bench UART host and lab host software use it to access SRAM and CSRs without the CPU.

---
 rtl/uart_wb_bridge.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_bridge.sv
// UART (8N1) command receiver that issues Wishbone master cycles and returns read data on tx.
// Optional: define UART_WB_RX_TIMEOUT_EN to abort partial frames after an idle gap.
module uart_wb_bridge #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int RX_TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx,
  output logic        tx,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   TO_END   =
    32'(RX_TIMEOUT_BITS * CLKS_PER_BIT - 1);

`ifdef UART_WB_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  typedef enum logic [3:0] {
    S_IDLE, S_SIZE, S_ADDR0, S_ADDR1,
    S_ADDR2, S_ADDR3, S_WDATA, S_WB_WR,
    S_WB_RD, S_TX_B3, S_TX_B2, S_TX_B1,
    S_TX_B0
  } st_t;

  rx_st_t         rx_st_q;
  logic           rx_m_q, rx_s_q, rx_p_q;
  logic [CW-1:0]  rx_cnt_q;
  logic [2:0]     rx_bit_q;
  logic [7:0]     rx_sh_q;
  logic [7:0]     rx_byte_q;
  logic           rx_vld_q, rx_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_p_q    <= 1'b1;
      rx_st_q   <= R_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_byte_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_m_q   <= rx;
      rx_s_q   <= rx_m_q;
      rx_p_q   <= rx_s_q;
      rx_vld_q <= 1'b0;
      rx_err_q <= 1'b0;
      unique case (rx_st_q)
        R_IDLE: begin
          if (rx_p_q && !rx_s_q) begin
            rx_st_q  <= R_START;
            rx_cnt_q <= '0;
          end
        end
        R_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            rx_st_q  <= R_IDLE;
            if (rx_s_q) begin
              rx_vld_q  <= 1'b1;
              rx_byte_q <= rx_sh_q;
            end else begin
              rx_err_q  <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  st_t           st_q;
  logic          wr_q;
  logic [7:0]    size_q;
  logic [31:0]   addr_q;
  logic [23:0]   wbuf_q;
  logic [1:0]    wbyte_q;
  logic [31:0]   rdata_q;
  logic          tx_q;
  logic [8:0]    tx_sh_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [31:0]   adr_q, dat_q;
  logic [3:0]    sel_q;
  logic          we_q, stb_q;
  logic [31:0]   to_cnt_q;

  logic [31:0] addr_d, wdat_d;
  logic        tx_tick_d, tx_end_d;
  logic        in_tx_d, in_frame_d;
  logic [7:0]  tx_nxt_d;

  assign addr_d    = {addr_q[23:0], rx_byte_q};
  assign wdat_d    = {wbuf_q, rx_byte_q};
  assign tx_tick_d = (tx_cnt_q == BIT_END);
  assign tx_end_d  = tx_tick_d && (tx_bit_q == 4'd9);
  assign in_tx_d   = st_q inside {S_TX_B3, S_TX_B2, S_TX_B1, S_TX_B0};
  assign in_frame_d =
    st_q inside {S_SIZE, S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3, S_WDATA};

  always_comb begin
    tx_nxt_d = '0;
    unique case (1'b1)
      st_q == S_TX_B3: tx_nxt_d = rdata_q[23:16];
      st_q == S_TX_B2: tx_nxt_d = rdata_q[15:8];
      st_q == S_TX_B1: tx_nxt_d = rdata_q[7:0];
      default:         tx_nxt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q     <= S_IDLE;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wbuf_q   <= '0;
      wbyte_q  <= '0;
      rdata_q  <= '0;
      tx_q     <= 1'b1;
      tx_sh_q  <= '0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      stb_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      // Bit timing; the state case below overrides it when a byte is reloaded.
      if (in_tx_d) begin
        if (tx_tick_d) begin
          tx_cnt_q <= '0;
          if (tx_bit_q != 4'd9) begin
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
            tx_bit_q <= tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      end

      unique case (st_q)
        S_IDLE: begin
          if (rx_vld_q && (rx_byte_q == 8'h01 || rx_byte_q == 8'h02)) begin
            wr_q <= (rx_byte_q == 8'h01);
            st_q <= S_SIZE;
          end
        end
        S_SIZE: begin
          if (rx_vld_q) begin
            size_q <= rx_byte_q;
            st_q   <= S_ADDR0;
          end
        end
        S_ADDR0: if (rx_vld_q) begin addr_q <= addr_d; st_q <= S_ADDR1; end
        S_ADDR1: if (rx_vld_q) begin addr_q <= addr_d; st_q <= S_ADDR2; end
        S_ADDR2: if (rx_vld_q) begin addr_q <= addr_d; st_q <= S_ADDR3; end
        S_ADDR3: begin
          if (rx_vld_q) begin
            addr_q <= addr_d;
            if (size_q == 8'd0) begin
              st_q <= S_IDLE;
            end else if (wr_q) begin
              wbyte_q <= '0;
              st_q    <= S_WDATA;
            end else begin
              adr_q <= addr_d;
              we_q  <= 1'b0;
              sel_q <= 4'hF;
              stb_q <= 1'b1;
              st_q  <= S_WB_RD;
            end
          end
        end
        S_WDATA: begin
          if (rx_vld_q) begin
            wbuf_q  <= wdat_d[23:0];
            wbyte_q <= wbyte_q + 2'd1;
            if (wbyte_q == 2'd3) begin
              adr_q <= addr_q;
              dat_q <= wdat_d;
              we_q  <= 1'b1;
              sel_q <= 4'hF;
              stb_q <= 1'b1;
              st_q  <= S_WB_WR;
            end
          end
        end
        S_WB_WR: begin
          if (wbm_ack_i) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= addr_q + 32'd4;
            size_q  <= size_q - 8'd1;
            wbyte_q <= '0;
            st_q    <= (size_q == 8'd1) ? S_IDLE : S_WDATA;
          end
        end
        S_WB_RD: begin
          if (wbm_ack_i) begin
            stb_q    <= 1'b0;
            sel_q    <= '0;
            rdata_q  <= wbm_dat_i;
            addr_q   <= addr_q + 32'd4;
            size_q   <= size_q - 8'd1;
            tx_q     <= 1'b0;
            tx_sh_q  <= {1'b1, wbm_dat_i[31:24]};
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            st_q     <= S_TX_B3;
          end
        end
        S_TX_B3, S_TX_B2, S_TX_B1: begin
          if (tx_end_d) begin
            tx_q     <= 1'b0;
            tx_sh_q  <= {1'b1, tx_nxt_d};
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            unique case (1'b1)
              st_q == S_TX_B3: st_q <= S_TX_B2;
              st_q == S_TX_B2: st_q <= S_TX_B1;
              default:         st_q <= S_TX_B0;
            endcase
          end
        end
        S_TX_B0: begin
          if (tx_end_d) begin
            tx_bit_q <= '0;
            if (size_q != 8'd0) begin
              adr_q <= addr_q;
              we_q  <= 1'b0;
              sel_q <= 4'hF;
              stb_q <= 1'b1;
              st_q  <= S_WB_RD;
            end else begin
              st_q <= S_IDLE;
            end
          end
        end
        default: st_q <= S_IDLE;
      endcase

      if (in_frame_d && rx_err_q) st_q <= S_IDLE;

      // Idle-gap counter restarts on every byte and while a character is arriving.
      if (TO_EN && in_frame_d) begin
        if (rx_vld_q || rx_st_q != R_IDLE) begin
          to_cnt_q <= '0;
        end else if (to_cnt_q == TO_END) begin
          to_cnt_q <= '0;
          st_q     <= S_IDLE;
        end else begin
          to_cnt_q <= to_cnt_q + 32'd1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign tx        = tx_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = stb_q;
  assign busy      = (st_q != S_IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: UART host driver, Wishbone slave, tx decoder and frame-level model.
// Build with UART_WB_RX_TIMEOUT_EN to exercise the idle-abort variant.
module tb_uart_wb_bridge;

  localparam int CPB = 16;
  localparam int TOB = 64;
  localparam int LIM = 20000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic        wbm_ack_i = 1'b0;
  logic        busy;

  uart_wb_bridge #(
    .CLKS_PER_BIT(CPB),
    .RX_TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .tx(tx),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  typedef struct packed {
    logic [7:0] b;
    logic       first;
    logic       chain;
  } txe_t;

  bus_t        exp_bus[$];
  txe_t        exp_tx[$];
  logic [7:0]  txlog[$];
  logic [31:0] mmem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];
  logic [31:0] wbuf[8];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wait_states = 0;
  int n_bus = 0;
  logic [31:0] last_adr = '0;
  logic [31:0] last_dat = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC3A5_0F96;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Single compare process: Wishbone slave, bus scoreboard and tx decoder.
  int   t_act = 0, t_start = 0, t_k = 0, prev_start = 0;
  int   ack_cyc = -1000, exp_rise = 0, ws_cnt = 0;
  logic [7:0] t_sh = '0;
  logic stb_prev = 1'b0;

  always @(negedge clk) begin
    bus_t be;
    txe_t te;
    cyc++;
    if (!resetn) begin
      t_act = 0; ws_cnt = 0; wbm_ack_i = 1'b0;
      stb_prev = 1'b0; exp_rise = 0;
    end else begin
      chk("stb_eq_cyc", 64'(wbm_cyc_o), 64'(wbm_stb_o));
      if (wbm_stb_o) chk("sel_during_cycle", 64'(wbm_sel_o), 64'hF);
      if (wbm_stb_o && !stb_prev && exp_rise != 0) begin
        chk("rd_burst_strobe_cycle", 64'(cyc), 64'(exp_rise));
        exp_rise = 0;
      end
      stb_prev = wbm_stb_o;

      if (wbm_stb_o && !wbm_ack_i) begin
        if (ws_cnt >= wait_states) begin
          ws_cnt = 0;
          wbm_ack_i = 1'b1;
          n_bus++;
          last_adr = wbm_adr_o;
          last_dat = wbm_dat_o;
          ack_cyc = cyc;
          if (exp_bus.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_bus: got adr %0h we %0b, required none",
                     wbm_adr_o, wbm_we_o);
          end else begin
            be = exp_bus.pop_front();
            chk("bus_we", 64'(wbm_we_o), 64'(be.we));
            chk("bus_adr", 64'(wbm_adr_o), 64'(be.adr));
            if (be.we) chk("bus_dat", 64'(wbm_dat_o), 64'(be.dat));
          end
          if (wbm_we_o) smem[wbm_adr_o] = wbm_dat_o;
          else wbm_dat_i = smem.exists(wbm_adr_o) ?
                           smem[wbm_adr_o] : dflt(wbm_adr_o);
        end else begin
          ws_cnt++;
        end
      end else begin
        wbm_ack_i = 1'b0;
      end

      if (t_act == 0) begin
        if (tx === 1'b0) begin
          t_act = 1; t_start = cyc; t_k = 0;
        end
      end else if (cyc - t_start == CPB / 2 + CPB * (t_k + 1)) begin
        if (t_k < 8) begin
          t_sh = {tx, t_sh[7:1]};
          t_k++;
        end else begin
          t_act = 0;
          chk("tx_stop_bit", 64'(tx), 64'h1);
          txlog.push_back(t_sh);
          if (exp_tx.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_tx: got %0h, required none", t_sh);
          end else begin
            te = exp_tx.pop_front();
            chk("tx_byte", 64'(t_sh), 64'(te.b));
            if (te.first)
              chk("tx_b3_after_ack", 64'(t_start), 64'(ack_cyc + 1));
            else
              chk("tx_byte_spacing", 64'(t_start),
                  64'(prev_start + 10 * CPB));
            if (te.chain) exp_rise = t_start + 10 * CPB;
          end
          prev_start = t_start;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 64'(n < LIM), 64'h1);
    chk("bus_queue_drained", 64'(exp_bus.size()), 64'h0);
    chk("tx_queue_drained", 64'(exp_tx.size()), 64'h0);
    repeat (4) @(negedge clk);
    chk("busy_low_after_frame", 64'(busy), 64'h0);
  endtask

  // Frame model: predicts bus cycles and tx bytes, then sends the frame.
  task automatic frame(input logic [7:0] cmd, input logic [7:0] size,
                       input logic [31:0] adr, input int gap);
    logic [31:0] a, w;
    bus_t be;
    txe_t te;
    a = adr;
    for (int i = 0; i < int'(size); i++) begin
      if (cmd == 8'h01) begin
        be = '{we: 1'b1, adr: a, dat: wbuf[i]};
        mmem[a] = wbuf[i];
        exp_bus.push_back(be);
      end else if (cmd == 8'h02) begin
        w = mmem.exists(a) ? mmem[a] : dflt(a);
        be = '{we: 1'b0, adr: a, dat: 32'h0};
        exp_bus.push_back(be);
        for (int k = 3; k >= 0; k--) begin
          te.b = w[8*k +: 8];
          te.first = (k == 3);
          te.chain = (k == 0) && (i < int'(size) - 1);
          exp_tx.push_back(te);
        end
      end
      a = a + 32'd4;
    end
    send_byte(cmd, 1'b0);
    send_byte(size, 1'b0);
    repeat (gap) @(negedge clk);
    for (int k = 3; k >= 0; k--) send_byte(adr[8*k +: 8], 1'b0);
    if (cmd == 8'h01)
      for (int i = 0; i < int'(size); i++)
        for (int k = 3; k >= 0; k--) send_byte(wbuf[i][8*k +: 8], 1'b0);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, base, n;
    logic [7:0] wfr[10];
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'h1);
    chk("rst_stb", 64'(wbm_stb_o), 64'h0);
    chk("rst_cyc", 64'(wbm_cyc_o), 64'h0);
    chk("rst_we", 64'(wbm_we_o), 64'h0);
    chk("rst_adr", 64'(wbm_adr_o), 64'h0);
    chk("rst_dat", 64'(wbm_dat_o), 64'h0);
    chk("rst_sel", 64'(wbm_sel_o), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    wbuf[0] = 32'h7755_55AB;
    frame(8'h01, 8'd1, 32'h0000_0110, 0);
    chk("t1_adr_literal", 64'(last_adr), 64'h110);
    chk("t1_dat_literal", 64'(last_dat), 64'h7755_55AB);
    chk("t1_bus_count", 64'(n_bus), 64'd1);

    wait_states = 2;
    base = txlog.size();
    frame(8'h02, 8'd1, 32'h0000_0110, 0);
    chk("t2_tx_literal", 64'({txlog[base], txlog[base+1],
                              txlog[base+2], txlog[base+3]}),
        64'h7755_55AB);

    wait_states = 0;
    wbuf[0] = 32'h0123_4567;
    wbuf[1] = 32'h89AB_CDEF;
    frame(8'h01, 8'd2, 32'h0000_0200, 0);
    chk("t3_last_adr_literal", 64'(last_adr), 64'h204);
    base = txlog.size();
    frame(8'h02, 8'd2, 32'h0000_0200, 0);
    chk("t3_word1_literal", 64'({txlog[base+4], txlog[base+5],
                                 txlog[base+6], txlog[base+7]}),
        64'h89AB_CDEF);

    nb = n_bus;
    send_byte(8'h55, 1'b0);
    frame(8'h02, 8'd1, 32'h0000_0204, 0);
    chk("t4_bus_count", 64'(n_bus), 64'(nb + 1));

    nb = n_bus;
    frame(8'h02, 8'd0, 32'h0000_0300, 0);
    frame(8'h01, 8'd0, 32'h0000_0300, 0);
    chk("t5_size0_no_cycle", 64'(n_bus), 64'(nb));

    nb = n_bus;
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_ferr_idle", 64'(busy), 64'h0);
    chk("t6_ferr_no_cycle", 64'(n_bus), 64'(nb));
    frame(8'h02, 8'd1, 32'h0000_0110, 0);

    wbuf[0] = 32'hDEAD_BEEF;
    wbuf[1] = 32'hCAFE_F00D;
    frame(8'h01, 8'd2, 32'hFFFF_FFFC, 0);
    chk("t7_wrap_adr_literal", 64'(last_adr), 64'h0);
    wait_states = 1;
    frame(8'h02, 8'd2, 32'hFFFF_FFFC, 0);
    frame(8'h02, 8'd1, 32'h0000_0113, 0);
    wait_states = 0;

    nb = n_bus;
`ifdef UART_WB_RX_TIMEOUT_EN
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("t8_busy_before_gap", 64'(busy), 64'h1);
    repeat (TOB * CPB + 50) @(negedge clk);
    chk("t8_timeout_idle", 64'(busy), 64'h0);
    chk("t8_timeout_no_cycle", 64'(n_bus), 64'(nb));
`else
    wbuf[0] = 32'h1357_9BDF;
    frame(8'h01, 8'd1, 32'h0000_0500, TOB * CPB + 50);
    chk("t8_late_frame_done", 64'(n_bus), 64'(nb + 1));
`endif

    wait_states = 1000;
    wfr = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 10; i++) send_byte(wfr[i], 1'b0);
    n = 0;
    while (!wbm_stb_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t9_stb_seen", 64'(wbm_stb_o), 64'h1);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("t9_async_stb", 64'(wbm_stb_o), 64'h0);
    chk("t9_async_cyc", 64'(wbm_cyc_o), 64'h0);
    chk("t9_async_busy", 64'(busy), 64'h0);
    chk("t9_async_tx", 64'(tx), 64'h1);
    chk("t9_async_adr", 64'(wbm_adr_o), 64'h0);
    wait_states = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    frame(8'h02, 8'd1, 32'h0000_0110, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
